key_event_queue: RTL and testbench
==================================

Name: key_event_queue

Overview:
- Sits directly downstream of keypad_controller and consumes its key_down, valid_key and key[3:0].
- Synchronises those slow, divider-derived signals into the system clock domain and detects press/release edges.
- Queues each edge as an event in a small first-word-fall-through FIFO for the game logic to pop with a valid/ready handshake.
- Records overflow so dropped key hits are visible to game logic.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- KEY_W, 4, key code width; matches keypad_controller key output.
- REPORT_RELEASE, 1, 1 = also queue release events; 0 = press events only.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- key_down  in  1  debounced key-held level from keypad_controller
- valid_key  in  1  key register holds a valid code
- key  in  KEY_W  registered key code from keypad_controller
- ev_ready  in  1  consumer accepts head event this cycle
- clr_overflow  in  1  synchronous clear of overflow and drop_count
- ev_valid  out  1  FIFO non-empty; head event presented
- ev_key  out  KEY_W  head event key code
- ev_press  out  1  head event type: 1 = press, 0 = release
- count  out  log2(DEPTH)+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: an event was dropped
- drop_count  out  8  dropped events, saturates at 255

Behaviour:
- Reset (async, active-high):
  - sync registers, edge register, last_key, FIFO pointers and count all 0.
  - ev_valid=0, ev_key=0, ev_press=0, overflow=0, drop_count=0.
  - key_down idle level is 0.
- Synchroniser: key_down and valid_key each pass through 2 flops (kd_s1→kd_s2, vk_s1→vk_s2). kd_d holds the previous kd_s2.
- Edge detect:
  - press_evt = kd_s2 & ~kd_d & vk_s2.
  - release_evt = ~kd_s2 & kd_d & vk_s2 & REPORT_RELEASE.
  - key[3:0] is sampled directly, with no synchroniser, in the cycle press_evt is true. It is stable by then because keypad_controller updates key on the key_down rising edge, at least 2 clk earlier.
- last_key loads key on press_evt. A release event carries last_key, not the current key.
- Push data is {type, code}; at most one push per cycle.
- Latency: key_down rises before edge E0 → kd_s1=1 after E0 → kd_s2=1 after E1 → entry written at E2 → ev_valid=1 after E2, i.e. 3 clk edges. Release has the same latency.
- FIFO:
  - DEPTH entries; write pointer and read pointer each log2(DEPTH) bits, wrapping modulo DEPTH.
  - First-word-fall-through: ev_key and ev_press always show the entry at the read pointer.
  - When empty, ev_key and ev_press hold their last value. The consumer must not use them while ev_valid=0.
- Pop occurs on ev_valid & ev_ready. ev_ready while empty is ignored; no pointer change.
- Push and pop in the same cycle:
  - Not full: both occur; count unchanged.
  - Full: both occur; the new entry is accepted, not dropped; count stays DEPTH.
  - Empty: push only. The pop is ignored because ev_valid=0 that cycle.
- Push while full with no pop:
  - The event is dropped; FIFO contents unchanged.
  - overflow←1; drop_count←drop_count+1, saturating at 255.
- clr_overflow: overflow←0 and drop_count←0 on the next edge. If a drop occurs in the same cycle, clear wins and the drop is not counted.
- count = entries stored, updated on the same edge as each push or pop.
- Reset mid-operation: FIFO is emptied immediately and all queued events are lost. A key held across reset deassertion produces a press event 3 edges later, because the sync registers restart at 0.
- Glitches on key_down shorter than 1 clk may be missed. Upstream debouncing makes this irrelevant.

Test Plan:
- Reset then idle: ev_valid=0, count=0, overflow=0, drop_count=0. Assert reset mid-queue with count=3 → count=0 and ev_valid=0 immediately (async).
- Single press: valid_key=1, key=4'b0110, key_down 0→1 → ev_valid=1 exactly 3 edges later with ev_key=6, ev_press=1. Pulse ev_ready 1 cycle → ev_valid=0, count=0.
- Release with REPORT_RELEASE=1: after press of key 6, change key to 9, then key_down 1→0 → second event ev_key=6, ev_press=0. With REPORT_RELEASE=0 → no second event.
- valid_key=0 during key_down toggles → no events queued, count stays 0.
- Overflow, DEPTH=4, ev_ready=0: 6 press/release pairs with REPORT_RELEASE=0 → count=4, overflow=1, drop_count=2, head entry = first key. Pulse clr_overflow → overflow=0, drop_count=0.
- Full and simultaneous: count=4, ev_ready=1 held, new press arrives → push accepted and pop occurs, count remains 4, overflow stays 0. Pops then return keys in arrival order; pointers wrap correctly past DEPTH.

Source files
------------

// File: rtl/key_event_queue.sv
// key_event_queue: synchronises keypad_controller outputs into the system
// clock domain, turns key_down edges into press/release events and queues
// them in a small first-word-fall-through FIFO with a valid/ready pop port.
// Dropped events on overflow are flagged and counted.
module key_event_queue #(
  parameter int DEPTH          = 4,
  parameter int KEY_W          = 4,
  parameter int REPORT_RELEASE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_down,
  input  logic                     valid_key,
  input  logic [KEY_W-1:0]         key,
  input  logic                     ev_ready,
  input  logic                     clr_overflow,
  output logic                     ev_valid,
  output logic [KEY_W-1:0]         ev_key,
  output logic                     ev_press,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic REL_EN = (REPORT_RELEASE != 0);

  // Two-flop synchronisers plus the delayed copy used for edge detection
  logic kd_s1, kd_s2, kd_d;
  logic vk_s1, vk_s2;
  logic [KEY_W-1:0] last_key;

  // FIFO storage: entry = {type, code}, type 1 = press
  logic [KEY_W:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  // Combinational control
  logic            press_evt, release_evt, push_evt;
  logic [KEY_W:0]  push_data;
  logic            full, do_pop, do_push, drop;
  logic [CW-1:0]   count_next;
  logic [PW-1:0]   rd_next;
  logic [KEY_W:0]  head_data;

  // Edge detection, push/pop arbitration and next-head selection
  always_comb begin
    press_evt   = kd_s2 & ~kd_d & vk_s2;
    release_evt = ~kd_s2 & kd_d & vk_s2 & REL_EN;
    push_evt    = press_evt | release_evt;
    // A release reports the key that was pressed, not whatever key shows now
    if (press_evt) begin
      push_data = {1'b1, key};
    end else begin
      push_data = {1'b0, last_key};
    end
    full    = (count == CNT_FULL);
    do_pop  = ev_valid & ev_ready;
    // When full, a simultaneous pop frees the slot so the push is accepted
    do_push = push_evt & (~full | do_pop);
    drop    = push_evt & full & ~do_pop;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
    if (do_pop) begin
      rd_next = rd_ptr + PTR_ONE;
    end else begin
      rd_next = rd_ptr;
    end
    // Head register: bypass the incoming entry when it becomes the only one,
    // otherwise show the stored entry; hold the last value when going empty
    if (count_next == CNT_ZERO) begin
      head_data = {ev_press, ev_key};
    end else if (do_push && (count == CW'(do_pop))) begin
      head_data = push_data;
    end else begin
      head_data = mem[rd_next];
    end
  end

  // Synchronise key_down/valid_key and remember the pressed key code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kd_s1    <= 1'b0;
      kd_s2    <= 1'b0;
      kd_d     <= 1'b0;
      vk_s1    <= 1'b0;
      vk_s2    <= 1'b0;
      last_key <= {KEY_W{1'b0}};
    end else begin
      kd_s1 <= key_down;
      kd_s2 <= kd_s1;
      kd_d  <= kd_s2;
      vk_s1 <= valid_key;
      vk_s2 <= vk_s1;
      if (press_evt) begin
        last_key <= key;
      end else begin
        last_key <= last_key;
      end
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {(KEY_W + 1){1'b0}};
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // Pointers, occupancy and registered head/valid outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      count    <= CNT_ZERO;
      ev_valid <= 1'b0;
      ev_key   <= {KEY_W{1'b0}};
      ev_press <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      rd_ptr   <= rd_next;
      count    <= count_next;
      ev_valid <= (count_next != CNT_ZERO);
      ev_key   <= head_data[KEY_W-1:0];
      ev_press <= head_data[KEY_W];
    end
  end

  // Sticky overflow flag and saturating drop counter; clear beats a drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end else begin
        drop_count <= drop_count;
      end
    end else begin
      overflow   <= overflow;
      drop_count <= drop_count;
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue. Two instances share stimulus:
// dut reports releases, dut0 reports presses only.
module tb_key_event_queue;

  logic       clk;
  logic       reset;
  logic       key_down;
  logic       valid_key;
  logic [3:0] key;
  logic       ev_ready;
  logic       clr_overflow;

  logic       ev_valid,  ev_valid0;
  logic [3:0] ev_key,    ev_key0;
  logic       ev_press,  ev_press0;
  logic [2:0] count,     count0;
  logic       overflow,  overflow0;
  logic [7:0] drop_count, drop_count0;

  int n_pass  = 0;
  int n_total = 0;

  key_event_queue #(.DEPTH(4), .KEY_W(4), .REPORT_RELEASE(1)) dut (
    .clk(clk), .reset(reset), .key_down(key_down), .valid_key(valid_key),
    .key(key), .ev_ready(ev_ready), .clr_overflow(clr_overflow),
    .ev_valid(ev_valid), .ev_key(ev_key), .ev_press(ev_press),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  key_event_queue #(.DEPTH(4), .KEY_W(4), .REPORT_RELEASE(0)) dut0 (
    .clk(clk), .reset(reset), .key_down(key_down), .valid_key(valid_key),
    .key(key), .ev_ready(ev_ready), .clr_overflow(clr_overflow),
    .ev_valid(ev_valid0), .ev_key(ev_key0), .ev_press(ev_press0),
    .count(count0), .overflow(overflow0), .drop_count(drop_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One press/release pair: key held for 3 edges, released for 3 edges
  task automatic pair(input logic [3:0] k);
    key      = k;
    key_down = 1'b1;
    repeat (3) tick();
    key_down = 1'b0;
    repeat (3) tick();
  endtask

  typedef struct {
    logic       kd;
    logic       vk;
    logic [3:0] k;
    logic       rdy;
    logic       chk_head;
    logic       e_valid;
    logic [3:0] e_key;
    logic       e_press;
    logic [2:0] e_cnt;
    logic [2:0] e_cnt0;
  } vec_t;

  vec_t tbl[21];

  initial begin
    // kd vk key rdy chk valid key press cnt cnt0 (outputs after the edge)
    tbl[0]  = '{1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[1]  = '{1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[2]  = '{1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[3]  = '{1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[4]  = '{1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 3'd1, 3'd1};
    tbl[5]  = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 3'd1, 3'd1};
    tbl[6]  = '{1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 3'd1, 3'd1};
    tbl[7]  = '{1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 3'd1, 3'd1};
    tbl[8]  = '{1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 3'd2, 3'd1};
    tbl[9]  = '{1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 3'd1, 3'd0};
    tbl[10] = '{1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 3'd0, 3'd0};
    tbl[11] = '{1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 3'd0, 3'd0};
    tbl[12] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[13] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[14] = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[15] = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[16] = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[17] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[18] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[19] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
    tbl[20] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0};
  end

  logic [3:0] exp_k  [4];
  logic       exp_p  [4];
  logic [3:0] exp_k0 [4];

  initial begin
    reset        = 1'b1;
    key_down     = 1'b0;
    valid_key    = 1'b0;
    key          = 4'd0;
    ev_ready     = 1'b0;
    clr_overflow = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_key", ev_key, 0);
    chk("rst_press", ev_press, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_valid", ev_valid, 0);
    chk("idle_count", count, 0);

    // Table: single press latency, release carrying last_key, pop, gated keys
    for (int i = 0; i < 21; i++) begin
      key_down  = tbl[i].kd;
      valid_key = tbl[i].vk;
      key       = tbl[i].k;
      ev_ready  = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), ev_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_count0", i), count0, tbl[i].e_cnt0);
      chk($sformatf("tbl%0d_valid0", i), ev_valid0, (tbl[i].e_cnt0 != 3'd0) ? 1 : 0);
      if (tbl[i].chk_head) begin
        chk($sformatf("tbl%0d_key", i), ev_key, tbl[i].e_key);
        chk($sformatf("tbl%0d_press", i), ev_press, tbl[i].e_press);
      end
    end
    ev_ready = 1'b0;

    // Overflow: 6 press/release pairs with no consumer
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    valid_key = 1'b1;
    repeat (2) tick();
    for (int i = 1; i <= 6; i++) begin
      pair(4'(i));
    end
    repeat (2) tick();
    chk("ovf_count0", count0, 4);
    chk("ovf_flag0", overflow0, 1);
    chk("ovf_drop0", drop_count0, 2);
    chk("ovf_head0", ev_key0, 1);
    chk("ovf_press0", ev_press0, 1);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 8);
    chk("ovf_head", ev_key, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_flag0", overflow0, 0);
    chk("clr_drop0", drop_count0, 0);
    chk("clr_flag", overflow, 0);
    chk("clr_drop", drop_count, 0);
    chk("clr_count", count, 4);

    // Full with simultaneous push and pop
    key      = 4'd7;
    key_down = 1'b1;
    tick();
    tick();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("sim_count", count, 4);
    chk("sim_count0", count0, 4);
    chk("sim_flag", overflow, 0);
    chk("sim_flag0", overflow0, 0);
    chk("sim_drop0", drop_count0, 0);

    // Drain in arrival order; read pointer wraps past DEPTH
    exp_k[0] = 4'd1; exp_p[0] = 1'b0;
    exp_k[1] = 4'd2; exp_p[1] = 1'b1;
    exp_k[2] = 4'd2; exp_p[2] = 1'b0;
    exp_k[3] = 4'd7; exp_p[3] = 1'b1;
    exp_k0[0] = 4'd2; exp_k0[1] = 4'd3; exp_k0[2] = 4'd4; exp_k0[3] = 4'd7;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_key", i), ev_key, exp_k[i]);
      chk($sformatf("drain%0d_press", i), ev_press, exp_p[i]);
      chk($sformatf("drain%0d_key0", i), ev_key0, exp_k0[i]);
      chk($sformatf("drain%0d_press0", i), ev_press0, 1);
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      chk($sformatf("drain%0d_count", i), count, 3 - i);
      chk($sformatf("drain%0d_count0", i), count0, 3 - i);
    end
    chk("drain_valid", ev_valid, 0);
    chk("drain_valid0", ev_valid0, 0);

    // Release of key 7 queues only where releases are reported
    key_down = 1'b0;
    repeat (3) tick();
    chk("rel7_count", count, 1);
    chk("rel7_key", ev_key, 7);
    chk("rel7_press", ev_press, 0);
    chk("rel7_count0", count0, 0);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("rel7_pop", count, 0);
    chk("empty_ready0", count0, 0);

    // Reset mid-queue, with a key held across reset deassertion
    for (int i = 10; i <= 12; i++) begin
      pair(4'(i));
    end
    chk("mid_count0", count0, 3);
    key      = 4'd5;
    key_down = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", ev_valid, 0);
    chk("arst_count0", count0, 0);
    chk("arst_valid0", ev_valid0, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("held_e1", count, 0);
    tick();
    chk("held_e2", count, 0);
    tick();
    chk("held_e3_valid", ev_valid, 1);
    chk("held_e3_key", ev_key, 5);
    chk("held_e3_press", ev_press, 1);
    chk("held_e3_valid0", ev_valid0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
